// File: rtl/ram_pointer_bank.sv
// Slot-card register window giving the Apple II bus NPTR SRAM address pointers
// with optional post-increment/decrement after each data access.
//   S   | meaning
//   0   | idle, no qualified PHI1 rising edge since reset
//   1   | step ripple: pointer byte 0 +/-1, carry recorded
//   2   | step ripple: byte 1 on carry
//   3   | step ripple: upper bits on carry, ripple flags cleared
//   4-5 | bus window opening (CSDBEN follows one clock later)
//   6   | register write commit, auto-step scheduling
//   7   | hold until the next PHI1 rising edge
module ram_pointer_bank #(
    parameter int ADDR_W = 20,
    parameter int NPTR   = 2
) (
    input  logic              C7M,
    input  logic              nRES,
    input  logic              PHI1,
    input  logic [3:0]        A,
    input  logic              nWE,
    input  logic              nDEVSEL,
    input  logic              nIOSEL,
    input  logic [7:0]        D_in,
    output logic [7:0]        D_out,
    output logic              D_oe,
    input  logic [7:0]        RD_in,
    output logic [7:0]        RD_out,
    output logic              RD_oe,
    output logic [ADDR_W-1:0] RA,
    output logic              RAMCS
);
    localparam int HI_W = ADDR_W - 16;

    logic                        phi1reg_q, phi0seen_q, regen_q, csdben_q;
    logic [2:0]                  s_q, s_d;
    logic [NPTR-1:0][ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]                  bank_q, bank_d, ctrl_q, ctrl_d;
    logic [NPTR-1:0]             step_q, step_d, cy1_q, cy1_d, cy2_q, cy2_d;

    logic [1:0]        slot, fld;
    logic              win, wr6, data_hit, data_sel;
    logic [ADDR_W-1:0] ra_ptr;

    assign slot     = A[3:2];
    assign fld      = A[1:0];
    assign win      = ~nDEVSEL & regen_q;
    assign wr6      = win & ~nWE & (s_q == 3'd6);
    assign data_sel = win & data_hit;

    always_comb begin
        s_d = s_q;
        if (PHI1 && !phi1reg_q && phi0seen_q) begin
            s_d = 3'd1;
        end else if (s_q != 3'd0 && s_q != 3'd7) begin
            s_d = s_q + 3'd1;
        end
    end

    always_comb begin
        D_out    = 8'hFF;
        ra_ptr   = '0;
        data_hit = 1'b0;
        for (int p = 0; p < NPTR; p++) begin
            if (int'(slot) == p) begin
                ra_ptr   = ptr_q[p];
                data_hit = (fld == 2'd3);
                case (fld)
                    2'd0: D_out = ptr_q[p][7:0];
                    2'd1: D_out = ptr_q[p][15:8];
                    2'd2: begin
                        D_out           = 8'hFF;
                        D_out[HI_W-1:0] = ptr_q[p][ADDR_W-1:16];
                    end
                    default: D_out = RD_in;
                endcase
            end
        end
        if (A == 4'hC) begin
            D_out = ctrl_q;
        end else if (A == 4'hF) begin
            D_out = bank_q;
        end
    end

    assign D_oe   = csdben_q & nWE & win;
    assign RAMCS  = csdben_q & data_sel;
    assign RD_oe  = RAMCS & ~nWE;
    assign RD_out = D_in;
    // Address is forced low in reset even though A keeps toggling on the bus.
    assign RA     = !nRES    ? '0 :
                    data_sel ? ra_ptr : {{(ADDR_W-12){1'b0}}, bank_q, A};

    always_comb begin
        ptr_d  = ptr_q;
        step_d = step_q;
        cy1_d  = cy1_q;
        cy2_d  = cy2_q;
        ctrl_d = ctrl_q;
        bank_d = bank_q;
        for (int p = 0; p < NPTR; p++) begin
            if (s_q == 3'd1 && step_q[p]) begin
                ptr_d[p][7:0] = ctrl_q[p] ? ptr_q[p][7:0] - 8'd1 : ptr_q[p][7:0] + 8'd1;
                cy1_d[p]      = ctrl_q[p] ? (ptr_q[p][7:0] == 8'h00) : (ptr_q[p][7:0] == 8'hFF);
                step_d[p]     = 1'b0;
            end
            if (s_q == 3'd2 && cy1_q[p]) begin
                ptr_d[p][15:8] = ctrl_q[p] ? ptr_q[p][15:8] - 8'd1 : ptr_q[p][15:8] + 8'd1;
                cy2_d[p]       = ctrl_q[p] ? (ptr_q[p][15:8] == 8'h00) : (ptr_q[p][15:8] == 8'hFF);
                cy1_d[p]       = 1'b0;
            end
            if (s_q == 3'd3 && cy2_q[p]) begin
                ptr_d[p][ADDR_W-1:16] = ctrl_q[p] ? ptr_q[p][ADDR_W-1:16] - HI_W'(1)
                                                  : ptr_q[p][ADDR_W-1:16] + HI_W'(1);
            end
            if (s_q == 3'd3) begin
                step_d[p] = 1'b0;
                cy1_d[p]  = 1'b0;
                cy2_d[p]  = 1'b0;
            end
            // A bus write to a pointer byte takes priority over any step result.
            if (wr6 && int'(slot) == p) begin
                case (fld)
                    2'd0:    ptr_d[p][7:0]         = D_in;
                    2'd1:    ptr_d[p][15:8]        = D_in;
                    2'd2:    ptr_d[p][ADDR_W-1:16] = D_in[HI_W-1:0];
                    default: ;
                endcase
            end
            if (s_q == 3'd6 && data_sel && int'(slot) == p && ctrl_q[4+p]) begin
                step_d[p] = 1'b1;
            end
        end
        if (wr6 && A == 4'hC) begin
            for (int p = 0; p < NPTR; p++) begin
                ctrl_d[p]   = D_in[p];
                ctrl_d[4+p] = D_in[4+p];
            end
        end
        if (wr6 && A == 4'hF) begin
            bank_d = D_in;
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            phi1reg_q  <= 1'b0;
            phi0seen_q <= 1'b0;
            s_q        <= 3'd0;
            regen_q    <= 1'b0;
            csdben_q   <= 1'b0;
            ptr_q      <= '0;
            bank_q     <= 8'h00;
            ctrl_q     <= 8'h00;
            step_q     <= '0;
            cy1_q      <= '0;
            cy2_q      <= '0;
        end else begin
            phi1reg_q <= PHI1;
            if (!PHI1) begin
                phi0seen_q <= 1'b1;
            end
            s_q      <= s_d;
            csdben_q <= s_q[2];
            if (s_q == 3'd4 && !nIOSEL) begin
                regen_q <= 1'b1;
            end
            ptr_q  <= ptr_d;
            bank_q <= bank_d;
            ctrl_q <= ctrl_d;
            step_q <= step_d;
            cy1_q  <= cy1_d;
            cy2_q  <= cy2_d;
        end
    end

endmodule

// File: tb/tb_ram_pointer_bank.sv
// Bench for ram_pointer_bank: 7-clock bus cycles against a transaction-level pointer model,
// directed scenarios pinned by literal values, then randomized bus traffic.
module tb_ram_pointer_bank;
    localparam int ADDR_W = 20;
    localparam int NPTR   = 2;
    localparam int HI_W   = ADDR_W - 16;

    logic              C7M = 1'b0;
    logic              nRES = 1'b1;
    logic              PHI1 = 1'b0;
    logic [3:0]        A = 4'h0;
    logic              nWE = 1'b1;
    logic              nDEVSEL = 1'b1;
    logic              nIOSEL = 1'b1;
    logic [7:0]        D_in = 8'h00;
    logic [7:0]        RD_in = 8'h00;
    logic [7:0]        D_out, RD_out;
    logic              D_oe, RD_oe, RAMCS;
    logic [ADDR_W-1:0] RA;

    ram_pointer_bank #(.ADDR_W(ADDR_W), .NPTR(NPTR)) dut (
        .C7M(C7M), .nRES(nRES), .PHI1(PHI1), .A(A), .nWE(nWE),
        .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .D_in(D_in), .D_out(D_out),
        .D_oe(D_oe), .RD_in(RD_in), .RD_out(RD_out), .RD_oe(RD_oe),
        .RA(RA), .RAMCS(RAMCS)
    );

    always #5 C7M = ~C7M;

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] m_ptr [NPTR];
    logic [7:0]        m_bank, m_ctrl;
    bit                m_step [NPTR];
    bit                m_regen;

    logic [31:0] last_ra;
    logic [7:0]  last_dout, last_rdout;
    logic        last_doe, last_ramcs, last_rdoe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctrl_mask();
        logic [7:0] m;
        m = 8'h00;
        for (int p = 0; p < NPTR; p++) begin
            m[p]   = 1'b1;
            m[4+p] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a, input logic [7:0] rdin);
        int p, f, hi;
        p = int'(a) / 4;
        f = int'(a) % 4;
        if (a == 4'hC) return m_ctrl;
        if (a == 4'hF) return m_bank;
        if (p >= NPTR) return 8'hFF;
        if (f == 0) return m_ptr[p][7:0];
        if (f == 1) return m_ptr[p][15:8];
        if (f == 2) begin
            hi = int'(m_ptr[p] >> 16) + 256 - (1 << HI_W);
            return 8'(hi);
        end
        return rdin;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPTR; p++) begin
            m_ptr[p]  = '0;
            m_step[p] = 1'b0;
        end
        m_bank  = 8'h00;
        m_ctrl  = 8'h00;
        m_regen = 1'b0;
    endtask

    task automatic do_reset();
        nRES = 1'b0;
        PHI1 = 1'b0;
        A    = 4'hB;
        #1;
        chk("rst_d_oe", 32'(D_oe), 32'd0);
        chk("rst_rd_oe", 32'(RD_oe), 32'd0);
        chk("rst_ramcs", 32'(RAMCS), 32'd0);
        chk("rst_ra", 32'(RA), 32'd0);
        repeat (2) @(negedge C7M);
        nRES = 1'b1;
        repeat (2) @(negedge C7M);
        model_reset();
    endtask

    // One bus cycle: PHI1 high for clocks 0-3, low for 4-6; called and returns at a falling edge.
    task automatic bus(input logic [3:0] a, input logic we_n, input logic dev_n, input logic io_n,
                       input logic [7:0] din, input logic [7:0] rdin, input int rst_at);
        bit          win, dhit, aborted;
        int          p;
        logic [31:0] exp_ra;
        aborted = 1'b0;
        for (int q = 0; q < NPTR; q++) begin
            if (m_step[q]) begin
                m_ptr[q]  = m_ctrl[q] ? m_ptr[q] - 1'b1 : m_ptr[q] + 1'b1;
                m_step[q] = 1'b0;
            end
        end
        A = a; nWE = we_n; nDEVSEL = dev_n; nIOSEL = io_n; D_in = din; RD_in = rdin;
        p = int'(a) / 4;
        win = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == rst_at) begin
                do_reset();
                aborted = 1'b1;
                break;
            end
            PHI1 = (i < 4);
            @(posedge C7M);
            @(negedge C7M);
            if (i == 4 && !io_n) m_regen = 1'b1;
            win  = m_regen && !dev_n;
            dhit = win && (p < NPTR) && (int'(a) % 4 == 3);
            if (i >= 1 && i <= 3) begin
                chk("idle_d_oe", 32'(D_oe), 32'd0);
                chk("idle_ramcs", 32'(RAMCS), 32'd0);
            end
            if (i == 4 || i == 5) begin
                if (dhit) exp_ra = 32'(m_ptr[p]);
                else      exp_ra = 32'(m_bank) * 16 + 32'(a);
                chk("d_oe", 32'(D_oe), 32'(win && we_n));
                if (win && we_n) chk("d_out", 32'(D_out), 32'(m_read(a, rdin)));
                chk("ramcs", 32'(RAMCS), 32'(dhit));
                chk("rd_oe", 32'(RD_oe), 32'(dhit && !we_n));
                chk("ra", 32'(RA), exp_ra);
                chk("rd_out", 32'(RD_out), 32'(din));
                if (i == 4) begin
                    last_ra = 32'(RA); last_dout = D_out; last_rdout = RD_out;
                    last_doe = D_oe; last_ramcs = RAMCS; last_rdoe = RD_oe;
                end
            end
        end
        if (!aborted) begin
            if (win && p < NPTR && int'(a) % 4 == 3 && m_ctrl[4+p]) m_step[p] = 1'b1;
            if (win && !we_n) begin
                if (a == 4'hC) m_ctrl = din & ctrl_mask();
                else if (a == 4'hF) m_bank = din;
                else if (p < NPTR) begin
                    case (int'(a) % 4)
                        0: m_ptr[p][7:0] = din;
                        1: m_ptr[p][15:8] = din;
                        2: m_ptr[p][ADDR_W-1:16] = din[HI_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus(a, 1'b0, 1'b0, 1'b1, d, 8'($urandom), -1);
    endtask
    task automatic rd(input logic [3:0] a);
        bus(a, 1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom), -1);
    endtask
    task automatic iosel();
        bus(4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, -1);
    endtask

    int         r, r2;
    logic [7:0] dv;

    initial begin
        #2;
        do_reset();

        wr(4'h0, 8'h12);
        rd(4'h0);
        chk("noregen_doe", 32'(last_doe), 32'd0);
        iosel();
        rd(4'h0);
        chk("noregen_ptr0", 32'(last_dout), 32'h00);
        chk("regen_doe", 32'(last_doe), 32'd1);

        wr(4'h0, 8'hFF); wr(4'h1, 8'hFF); wr(4'h2, 8'h0F); wr(4'hC, 8'h10);
        rd(4'h3);
        chk("inc_wrap_ra", last_ra, 32'h0FFFFF);
        rd(4'h0);
        chk("inc_wrap_b0", 32'(last_dout), 32'h00);
        rd(4'h2);
        chk("inc_wrap_hi", 32'(last_dout), 32'hF0);
        chk("model_ptr0_wrap", 32'(m_ptr[0]), 32'h0);

        wr(4'hC, 8'h11);
        rd(4'h3);
        chk("dec_wrap_ra", last_ra, 32'h0);
        rd(4'h0);
        chk("dec_wrap_b0", 32'(last_dout), 32'hFF);
        rd(4'h2);
        chk("dec_wrap_hi", 32'(last_dout), 32'hFF);

        wr(4'hC, 8'h22); wr(4'h4, 8'h00); wr(4'h5, 8'h00); wr(4'h6, 8'h01);
        bus(4'h7, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, -1);
        chk("dwr_ramcs", 32'(last_ramcs), 32'd1);
        chk("dwr_rdoe", 32'(last_rdoe), 32'd1);
        chk("dwr_rdout", 32'(last_rdout), 32'hA5);
        chk("dwr_ra", last_ra, 32'h10000);
        rd(4'h4);
        chk("dec1_b0", 32'(last_dout), 32'hFF);
        rd(4'h5);
        chk("dec1_b1", 32'(last_dout), 32'hFF);
        rd(4'h6);
        chk("dec1_hi", 32'(last_dout), 32'hF0);
        rd(4'hC);
        chk("ctrl_rd", 32'(last_dout), 32'h22);

        wr(4'h2, 8'h05);
        rd(4'h2);
        chk("hi_ones", 32'(last_dout), 32'hF5);
        rd(4'hD);
        chk("unmapped", 32'(last_dout), 32'hFF);

        wr(4'hC, 8'h10); wr(4'h0, 8'hFE); wr(4'h1, 8'h00); wr(4'h2, 8'h00);
        rd(4'h3);
        chk("seq_ra0", last_ra, 32'hFE);
        rd(4'h3);
        chk("seq_ra1", last_ra, 32'hFF);
        rd(4'h3);
        chk("seq_ra2", last_ra, 32'h100);

        wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h0, 8'hFF);
        rd(4'h3);
        bus(4'h0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 2);
        iosel();
        rd(4'h0);
        chk("rstmid_b0", 32'(last_dout), 32'h00);
        rd(4'h1);
        chk("rstmid_b1", 32'(last_dout), 32'h00);
        rd(4'h2);
        chk("rstmid_hi", 32'(last_dout), 32'hF0);
        rd(4'h4);
        chk("rstmid_p1", 32'(last_dout), 32'h00);

        for (int k = 0; k < 400; k++) begin
            r  = int'($urandom_range(0, 99));
            r2 = int'($urandom_range(0, 99));
            if (r2 < 15)      dv = 8'hFF;
            else if (r2 < 30) dv = 8'h00;
            else              dv = 8'($urandom);
            if (r < 2)
                bus(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b1, dv, 8'($urandom),
                    int'($urandom_range(1, 5)));
            else
                bus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), (r < 6) ? 1'b0 : 1'b1, dv, 8'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_pointer_bank.md
RAM_POINTER_BANK -- requirements
Module: ram_pointer_bank

Interface
REQ-001 Parameter ADDR_W, default 20, width of each RAM address pointer; legal range 17..24.
REQ-002 Parameter NPTR, default 2, number of independent address pointers; legal range 1..3.
REQ-003 C7M  input  1  7.16 MHz bus clock; all state updates on its rising edge.
REQ-004 nRES  input  1  reset; asynchronous, active-low.
REQ-005 PHI1  input  1  delayed/conditioned Apple II PHI1 phase.
REQ-006 A  input  4  Apple II address bits 3:0.
REQ-007 nWE  input  1  6502 R/W; low = write.
REQ-008 nDEVSEL, nIOSEL  input  1 each  card select strobes, active-low.
REQ-009 D_in  input  8  Apple II data bus, sampled value.
REQ-010 D_out  output  8  Apple II data bus drive value.
REQ-011 D_oe  output  1  Apple II data bus output enable.
REQ-012 RD_in  input  8  SRAM data bus, sampled value.
REQ-013 RD_out  output  8  SRAM write data, equals D_in.
REQ-014 RD_oe  output  1  SRAM data bus output enable.
REQ-015 RA  output  ADDR_W  SRAM address.
REQ-016 RAMCS  output  1  SRAM chip select, active-high.

Function
REQ-017 Phase tracking: PHI1reg <= PHI1 each clock; PHI0seen set when PHI1 is sampled low, cleared only by reset.
REQ-018 State counter S (3 bits): S<=1 when PHI1 & ~PHI1reg & PHI0seen; else S==0 holds 0, S==7 holds 7, otherwise S<=S+1.
REQ-019 CSDBEN <= (S in 4..7); REGEN set when S==4 & ~nIOSEL and stays set until reset.
REQ-020 Register window (nDEVSEL low, REGEN set), offset A: 4p+0 = PTRp[7:0], 4p+1 = PTRp[15:8], 4p+2 = PTRp[ADDR_W-1:16], 4p+3 = DATAp (SRAM through PTRp), 0xC = CTRL, 0xF = BANK; all other offsets, including unused pointer slots, are unmapped.
REQ-021 CTRL bit p = DECp (1 = post-decrement, 0 = post-increment); CTRL bit 4+p = AUTOp (1 = step after data access); all other CTRL bits read 0.
REQ-022 Register writes commit at S==6 from D_in; the hi-byte write takes D_in[ADDR_W-17:0].
REQ-023 Reads: the hi byte returns the pointer's upper bits with unused upper bits set to 1; DATAp returns RD_in; unmapped offsets return 0xFF.
REQ-024 D_oe = CSDBEN & nWE & ~nDEVSEL & REGEN; otherwise D_out is don't-care.
REQ-025 RA = PTRp while DATAp is addressed; otherwise RA = {BANK, A[3:0]} zero-extended to ADDR_W.
REQ-026 RAMCS = CSDBEN & data offset selected & ~nDEVSEL & REGEN; RD_oe = RAMCS & ~nWE.
REQ-027 Step scheduling: at S==6, a DATAp access with AUTOp=1 sets pending step STEPp.
REQ-028 Step execution, ripple across states of the next bus cycle: at S==1, byte 0 is updated ±1 and the carry/borrow is recorded; at S==2, byte 1 is updated only on carry; at S==3, the upper bits are updated only on carry; all pending flags clear by the end of S==3.
REQ-029 Wrap: an increment from 2^ADDR_W-1 gives 0; a decrement from 0 gives 2^ADDR_W-1.
REQ-030 A pointer byte written at S==6 overrides any step result for that byte; a step still pending for that pointer uses the newly written value.
REQ-031 Multiple pointers step independently in the same bus cycle.
REQ-032 If S stays at 0 (PHI1 never toggles), no register is written and no step executes.

Reset
REQ-033 nRES low asynchronously clears PHI1reg, PHI0seen, S, REGEN, CSDBEN, all PTRp, BANK, CTRL, and all step flags.
REQ-034 While in reset: D_oe=0, RD_oe=0, RAMCS=0, RA=0.
REQ-035 Reset mid-ripple cancels the remaining carry stages; the bus cycle after release performs no step.

Verification
REQ-036 Reset release, no IOSEL access, write 0x12 to offset 0 -> PTR0 unchanged, D_oe stays 0 (REGEN clear).
REQ-037 IOSEL access, then write PTR0 = 0x0FFFFF, AUTO0=1, read DATA0 -> RA=0x0FFFFF during S4..7; PTR0 = 0x000000 after S3 of the next cycle.
REQ-038 DEC1=1, AUTO1=1, PTR1 = 0x010000, write DATA1 -> RAMCS=1, RD_oe=1, RD_out=D_in; PTR1 = 0x00FFFF after the next S3.
REQ-039 Read offset 2 with PTR0 = 0x5xxxx (ADDR_W=20) -> D_out = 0xF5; read offset 0xD -> 0xFF.
REQ-040 Assert nRES at S==2 with the carry pending from PTR0 = 0x0000FF -> all pointers read 0 after release.
REQ-041 Back-to-back DATA0 reads with AUTO0=1 starting at 0x0000FE -> RA sequence 0xFE, 0xFF, 0x100.
